// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: access types, FSM encodings, sizing.
package dm_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int DM_AW    = 12;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Codes 5-7 behave as full-word accesses.
    function automatic logic dm_is_word(input logic [2:0] typ);
        return !(typ == DM_H || typ == DM_HU || typ == DM_B || typ == DM_BU);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] typ, input logic [1:0] a);
        if (dm_is_word(typ))
            return a != 2'd0;
        else if (typ == DM_H || typ == DM_HU)
            return a[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Lane logic: load sub-word extract/extend and store read-modify-write merge.
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] half_merge;
    logic [31:0] byte_merge;

    always_comb begin
        half_v     = addr[1] ? word[31:16] : word[15:0];
        half_merge = addr[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
        case (addr)
            2'd0:    begin byte_v = word[7:0];   byte_merge = {word[31:8], wdata[7:0]}; end
            2'd1:    begin byte_v = word[15:8];  byte_merge = {word[31:16], wdata[7:0], word[7:0]}; end
            2'd2:    begin byte_v = word[23:16]; byte_merge = {word[31:24], wdata[7:0], word[15:0]}; end
            default: begin byte_v = word[31:24]; byte_merge = {wdata[7:0], word[23:0]}; end
        endcase

        load_val = word;
        merged   = wdata;
        case (typ)
            DM_H:    begin load_val = {{16{half_v[15]}}, half_v}; merged = half_merge; end
            DM_HU:   begin load_val = {16'd0, half_v};            merged = half_merge; end
            DM_B:    begin load_val = {{24{byte_v[7]}}, byte_v};  merged = byte_merge; end
            DM_BU:   begin load_val = {24'd0, byte_v};            merged = byte_merge; end
            default: begin load_val = word;                       merged = wdata;      end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master round-robin controller for the 32-bit word data memory.
// Optional store trace enabled by defining DM_ARB_TRACE_EN.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [2:0]    m0_type,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [31:0]   m0_pc,
    output logic          m0_done,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [2:0]    m1_type,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [31:0]   m1_pc,
    output logic          m1_done,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbg_state,
    output logic [31:0]   dbg_pc,
    output logic [31:0]   dbg_addr
);

    // Handshake: a master holds req and its fields stable until the cycle its
    // done pulses; it must drop req or present a new op in the following cycle.

    if (DEPTH > (1 << AW)) begin : g_depth_chk
        $error("dm_arbiter: AW too narrow for DEPTH");
    end

    logic [1:0]  state;
    logic        last_grant;
    logic        gnt;
    logic        l_we;
    logic [2:0]  l_type;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] l_pc;

    logic        win;
    logic        misal;
    logic        is_word;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] load_val;
    logic [31:0] merged;

    // On a tie the master that did not win last time is granted.
    assign win     = (m0_req && m1_req) ? ~last_grant : m1_req;
    assign misal   = dm_misaligned(l_type, l_addr[1:0]);
    assign is_word = dm_is_word(l_type);

    dm_lane u_lane (
        .typ      (l_type),
        .addr     (l_addr[1:0]),
        .word     (mem_rdata),
        .wdata    (l_wdata),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            l_we       <= 1'b0;
            l_type     <= DM_W;
            l_addr     <= 32'd0;
            l_wdata    <= 32'd0;
            l_pc       <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt        <= win;
                        last_grant <= win;
                        l_we       <= win ? m1_we    : m0_we;
                        l_type     <= win ? m1_type  : m0_type;
                        l_addr     <= win ? m1_addr  : m0_addr;
                        l_wdata    <= win ? m1_wdata : m0_wdata;
                        l_pc       <= win ? m1_pc    : m0_pc;
                        state      <= ST_ACC;
                    end
                end
                ST_ACC:  state <= (misal || (l_we && is_word)) ? ST_IDLE : ST_DATA;
                ST_DATA: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an abandoned transaction neither writes nor completes.
    always_comb begin
        done      = 1'b0;
        err       = 1'b0;
        rdata     = 32'd0;
        mem_we    = 1'b0;
        mem_wdata = l_wdata;
        if (reset) begin
            case (state)
                ST_ACC: begin
                    if (misal) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (l_we && is_word) begin
                        mem_we = 1'b1;
                        done   = 1'b1;
                    end
                end
                ST_DATA: begin
                    done = 1'b1;
                    if (l_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = merged;
                    end else begin
                        rdata = load_val;
                    end
                end
                default: ;
            endcase
        end
        m0_done  = done && !gnt;
        m0_err   = err && !gnt;
        m0_rdata = gnt ? 32'd0 : rdata;
        m1_done  = done && gnt;
        m1_err   = err && gnt;
        m1_rdata = gnt ? rdata : 32'd0;
    end

    assign mem_addr  = l_addr[AW+1:2];
    assign dbg_state = state;
    assign dbg_pc    = l_pc;
    assign dbg_addr  = l_addr;

`ifdef DM_ARB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && mem_we)
            $display("@%h: *%h <= %h", l_pc, {l_addr[31:2], 2'b00}, mem_wdata);
    end
`else
`endif

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master controller in front of the word-organised data memory (3072 x 32, word-addressed by addr[13:2], synchronous 1-cycle read).
- Round-robin arbitration between master 0 (CPU load/store unit) and master 1 (DMA/loader).
- Loads: extracts and extends sub-words.
- Sub-word stores: performed as read-modify-write.
- Misaligned accesses are rejected with an error.

Parameters:
- DEPTH, 3072, memory depth in words.
- AW, 12, word-address width driven to memory (byte addr bits [13:2]).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- m0_req  in  1  master 0 request; held with fields stable until m0_done.
- m0_we  in  1  1 = store, 0 = load.
- m0_type  in  3  access type, dm_pkg encoding.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  store data, right-aligned for sub-words.
- m0_pc  in  32  PC of the issuing instruction, for trace.
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  32  load result, valid with m0_done.
- m0_err  out  1  misalignment flag, valid with m0_done.
- m1_*  same set as m0_*, master 1.
- mem_addr  out  AW  word address.
- mem_we  out  1  word write enable.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid the cycle after mem_addr is presented.

Behaviour:
- Type encoding: 0 W, 1 H, 2 HU, 3 B, 4 BU; 5-7 are treated as W.
  - Stores: H/HU both mean halfword; B/BU both mean byte.
- Reset (reset==0 at a posedge):
  - state=IDLE, last_grant=1 (master 0 wins the first tie).
  - All done/err=0, rdata=0, mem_we=0.
  - A transaction in flight is abandoned: no write in the reset cycle, no done pulse.
- States IDLE, ACC, DATA.
- IDLE:
  - If any req is high, latch winner index plus its we/type/addr/wdata/pc; go to ACC.
  - Winner: sole requester; if both request, the one != last_grant.
  - last_grant updates on the latch.
  - mem_we=0 in IDLE.
- ACC (mem_addr = latched addr[13:2]):
  - Misaligned (W with addr[1:0]!=0, or H/HU with addr[0]=1): done+err=1, no write, go to IDLE.
  - Word store: mem_we=1, mem_wdata=wdata, done=1, go to IDLE.
  - Load or sub-word store: mem_we=0, go to DATA.
- DATA (mem_rdata valid):
  - Load: rdata is the selected lane.
    - Half lane: addr[1]. Byte lane: addr[1:0].
    - H/B sign-extend; HU/BU zero-extend; W passes the word through.
    - done=1, go to IDLE.
  - Sub-word store: mem_we=1, mem_wdata = mem_rdata with the addressed lane replaced by wdata[15:0] or wdata[7:0]; done=1, go to IDLE.
- Latency from the req-sampling cycle T:
  - Word store and error: done at T+1.
  - Load and sub-word store: done at T+2.
  - IDLE is revisited every transaction, so back-to-back throughput is 1 op per 2 or 3 cycles.
- Master rules:
  - Deassert req (or present a new op) in the cycle after done.
  - req still high in IDLE is a new request.
- done/rdata/err are decoded combinationally from the state; only the granted master's outputs are non-zero.
- Starvation:
  - Both masters requesting continuously alternate 0,1,0,1.
  - A lone requester is served back-to-back.
- Address bits [31:14] are ignored.
- Word index >= DEPTH: access passes through unchecked (memory-side responsibility).

Optional Feature:
- DM_ARB_TRACE_EN: on every cycle with mem_we=1 and reset high, $display "@%h: *%h <= %h" with latched pc, byte address with [1:0] cleared, and mem_wdata.
  - For sub-word stores this prints the merged word.
- Without the macro: no display statements; no functional difference.

Decomposition:
- dm_pkg holds:
  - type codes DM_W=0, DM_H=1, DM_HU=2, DM_B=3, DM_BU=4.
  - state encodings IDLE/ACC/DATA.
  - DEPTH default.
- One natural sub-module, dm_lane: combinational load extract/extend and store merge. Inputs: type, addr[1:0], word, wdata. Outputs: load value, merged word.

Test Plan:
- Reset with m0_req high -> no done for the reset cycle; after release m0 wins a tie; all outputs 0 during reset.
- m0 store W 0x12345678 @0x10, then load W @0x10 -> mem_we at T+1 with mem_addr=4; load done at T+2 with rdata 0x12345678.
- Word 0x12345678 @0x10; m1 store B 0xAB @0x13, then load BU @0x13 and B @0x13:
  - Stored word becomes 0xAB345678.
  - BU returns 0x000000AB; B returns 0xFFFFFFAB.
- Store H 0x8001 @0x12 over 0xAB345678 -> 0x80015678; load H @0x12 -> 0xFFFF8001; load HU -> 0x00008001.
- Both reqs held for 4 transactions -> grants alternate m0,m1,m0,m1; each done pulse is exactly one cycle on the granted master only.
- Load W @0x11 and store H @0x13 -> done+err at T+1, mem_we never asserted, memory unchanged; reset asserted in DATA of a sub-word store -> no write, no done.
